// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Sits between the UART receiver and the instruction memory. After the debug
// unit pulses i_start, received bytes are packed big-endian into 32-bit
// instructions. Each complete instruction is written to consecutive byte
// addresses 0, 4, 8, ... The load ends in DONE when the halt instruction has
// been written, or in ERROR if the last memory slot is written without
// seeing halt.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       one-cycle pulse that begins a load (ignored while loading)
//   i_rx_data     received byte
//   i_rx_valid    one-cycle strobe qualifying i_rx_data
//   o_addr        byte address of the current/last write (multiple of 4)
//   o_data        instruction word of the current/last write
//   o_wr_en       one-cycle write pulse to the instruction memory
//   o_busy        load in progress
//   o_done        halt instruction written
//   o_error       memory filled without a halt instruction
//   o_word_count  words written in the current or last load, halt included
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int                   NBITS     = 8,
  parameter int                   INST_BITS = 32,
  parameter int                   CELLS     = 256,
  parameter logic [INST_BITS-1:0] HALT_INST = 32'hFFFFFFFF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [NBITS-1:0]          i_rx_data,
  input  logic                      i_rx_valid,
  output logic [INST_BITS-1:0]      o_addr,
  output logic [INST_BITS-1:0]      o_data,
  output logic                      o_wr_en,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [$clog2(CELLS/4):0]  o_word_count
);

  // state   | meaning
  // --------+----------------------------------------------------------
  // S_IDLE  | out of reset, waiting for i_start; bytes ignored
  // S_LOAD  | assembling bytes into words and writing them
  // S_DONE  | halt instruction written; waiting for a new i_start
  // S_ERROR | last slot written without halt; waiting for a new i_start
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam int BPW   = INST_BITS / NBITS;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CNT_W = $clog2(CELLS/4) + 1;

  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(BPW - 1);
  localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - 4);
  localparam logic [INST_BITS-1:0] ADDR_STEP = INST_BITS'(4);

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_byte_idx;
  logic [INST_BITS-1:0] r_word;
  logic [INST_BITS-1:0] r_wr_addr;

  logic [INST_BITS-1:0] w_word_next;
  logic                 w_is_halt;
  logic                 w_is_last;

  // First byte received ends up in the MSB after BPW shifts.
  assign w_word_next = {r_word[INST_BITS-NBITS-1:0], i_rx_data};
  assign w_is_halt   = (w_word_next == HALT_INST);
  assign w_is_last   = (r_wr_addr == LAST_ADDR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_wr_addr    <= '0;
      o_addr       <= '0;
      o_data       <= '0;
      o_wr_en      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (i_rx_valid) begin
            r_word <= w_word_next;
            if (r_byte_idx == LAST_IDX) begin
              r_byte_idx   <= '0;
              o_wr_en      <= 1'b1;
              o_data       <= w_word_next;
              o_addr       <= r_wr_addr;
              r_wr_addr    <= r_wr_addr + ADDR_STEP;
              o_word_count <= o_word_count + CNT_W'(1);
              // Halt wins over the full check when it lands in the last slot.
              if (w_is_halt) begin
                r_state <= S_DONE;
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
              end else if (w_is_last) begin
                r_state <= S_ERROR;
                o_busy  <= 1'b0;
                o_error <= 1'b1;
              end
            end else begin
              r_byte_idx <= r_byte_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR all restart the same way; a byte strobe
          // coinciding with the start is dropped, and any partial word is
          // discarded by clearing the byte index.
          if (i_start) begin
            r_state      <= S_LOAD;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_wr_addr    <= '0;
            o_word_count <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] addr;
  logic [31:0] data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  word_count;

  int total = 0;
  int bad   = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  program_loader dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_addr       (addr),
    .o_data       (data),
    .o_wr_en      (wr_en),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_writes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%h want none", addr, data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({addr, data} !== exp_e) begin
          bad++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   addr, data, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic put_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w);
    put_byte(w[31:24]);
    put_byte(w[23:16]);
    put_byte(w[15:8]);
    put_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  int n0;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    check("rst_outputs", {addr, data}, 64'h0);
    check("rst_flags", {wr_en, busy, done, error, word_count}, 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Test 1: small program ending in halt
    pulse_start();
    check("t1_busy", {busy, done, error}, 64'b100);
    expect_wr(32'd0,  32'h3C0A0002);
    expect_wr(32'd4,  32'h3C0A0003);
    expect_wr(32'd8,  32'h012A5821);
    expect_wr(32'd12, 32'hFFFFFFFF);
    put_word(32'h3C0A0002);
    put_word(32'h3C0A0003);
    put_word(32'h012A5821);
    put_word(32'hFFFFFFFF);
    idle(1);
    check("t1_flags", {busy, done, error}, 64'b010);
    check("t1_count", word_count, 64'd4);

    // Test 2: pulse timing, and a byte arriving in the write-pulse cycle
    pulse_start();
    expect_wr(32'd0, 32'h12345678);
    expect_wr(32'd4, 32'h9ABCDEF0);
    put_byte(8'h12); idle(1);
    put_byte(8'h34); idle(1);
    put_byte(8'h56); idle(1);
    check("t2_no_early_wr", wr_en, 64'd0);
    put_byte(8'h78);
    check("t2_wr_pulse", {wr_en, addr, data}, {31'd0, 1'b1, 32'd0, 32'h12345678});
    put_byte(8'h9A);
    check("t2_wr_one_cycle", wr_en, 64'd0);
    put_byte(8'hBC);
    put_byte(8'hDE);
    put_byte(8'hF0);
    check("t2_wr2_pulse", {wr_en, addr}, {31'd0, 1'b1, 32'd4});
    idle(1);
    check("t2_hold", {wr_en, addr, data}, {31'd0, 1'b0, 32'd4, 32'h9ABCDEF0});
    check("t2_count", word_count, 64'd2);

    // Test 4: reset mid-word
    put_byte(8'hAA);
    put_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    check("t4_rst_bus", {addr, data}, 64'h0);
    check("t4_rst_flags", {wr_en, busy, done, error, word_count}, 64'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    pulse_start();
    expect_wr(32'd0, 32'hAABBCCDD);
    put_word(32'hAABBCCDD);
    idle(1);
    check("t4_after", {busy, word_count}, {56'd0, 1'b1, 7'd1});

    // Test 5: bytes before start, start mid-load ignored, restart after DONE
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    n0 = n_writes;
    put_word(32'h01020304);
    put_word(32'hFFFFFFFF);
    idle(1);
    check("t5_idle_no_wr", n_writes, n0);
    check("t5_idle_busy", {busy, word_count}, 64'd0);
    pulse_start();
    expect_wr(32'd0, 32'h11223344);
    expect_wr(32'd4, 32'hFFFFFFFF);
    put_byte(8'h11);
    put_byte(8'h22);
    pulse_start();
    put_byte(8'h33);
    put_byte(8'h44);
    put_word(32'hFFFFFFFF);
    idle(1);
    check("t5_done", {busy, done, error, word_count}, {54'd0, 3'b010, 7'd2});
    // start and a byte strobe together: start wins, byte dropped
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    check("t5_restart", {busy, done, error, word_count}, {54'd0, 3'b100, 7'd0});
    expect_wr(32'd0, 32'h55667788);
    put_word(32'h55667788);
    idle(1);

    // Test 3: fill memory without halt
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    pulse_start();
    n0 = n_writes;
    for (int i = 0; i < 64; i++) begin
      expect_wr(32'(i * 4), 32'h00000000);
      put_word(32'h00000000);
    end
    check("t3_last_addr", addr, 64'd252);
    idle(1);
    check("t3_nwrites", n_writes - n0, 64'd64);
    check("t3_flags", {busy, done, error, word_count}, {54'd0, 3'b001, 7'd64});
    n0 = n_writes;
    put_word(32'h01234567);
    put_word(32'h89ABCDEF);
    idle(2);
    check("t3_no_wr_after_err", n_writes, n0);
    check("t3_err_hold", {error, word_count}, {56'd0, 1'b1, 7'd64});

    // Test 6: halt in the last slot beats the full condition
    pulse_start();
    for (int i = 0; i < 63; i++) begin
      expect_wr(32'(i * 4), 32'h01020304);
      put_word(32'h01020304);
    end
    expect_wr(32'd252, 32'hFFFFFFFF);
    put_word(32'hFFFFFFFF);
    idle(1);
    check("t6_flags", {busy, done, error, word_count}, {54'd0, 3'b010, 7'd64});
    check("t6_addr", addr, 64'd252);

    idle(4);
    check("queue_empty", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
